// File: rtl/elevator_pkg.sv
// elevator_pkg: state encoding, direction codes and timer sizing shared by the elevator controller.
package elevator_pkg;
    localparam int FLOOR_W = 3;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVING    = 2'd1,
        ST_DOOR_OPEN = 2'd2
    } state_e;
    function automatic int timer_width(input int a, input int b);
        int m;
        m = a > b ? a : b;
        return m > 1 ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/elevator_timer.sv
// elevator_timer: loadable down-counter that saturates at zero; shared by travel and door phases.
module elevator_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/elevator_controller.sv
// elevator_controller: latches floor calls and serves them with a collective (SCAN) policy,
// timing floor-to-floor travel and door dwell with a single shared down-counter.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 50000000,
    parameter int DOOR_CYCLES   = 100000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  direction,
    output logic                  open,
    output logic                  moving,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam int TW = timer_width(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

    state_e                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d, step_floor, ref_floor;
    logic                  dir_q, dir_d, open_q, moving_q;
    logic [NUM_FLOORS-1:0] pend_q, pend_d, at, above, below, req, view;
    logic                  hit, up_req, dn_req, ahead, behind, door_call;
    logic                  t_load, t_zero;
    logic [TW-1:0]         t_val;

    elevator_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (t_load),
        .load_val_i (t_val),
        .en_i       (state_q != ST_IDLE),
        .zero_o     (t_zero)
    );

    always_comb begin
        step_floor = dir_q == DIR_UP ? floor_q + 1'b1 : floor_q - 1'b1;
        // While moving, every mask is taken relative to the floor being arrived at
        ref_floor = state_q == ST_MOVING ? step_floor : floor_q;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            at[i] = i == int'(ref_floor);
            above[i] = i > int'(ref_floor);
            below[i] = i < int'(ref_floor);
        end
        door_call = state_q == ST_DOOR_OPEN && |(call_req & at);
        req = pend_q | (call_req & ~(state_q == ST_DOOR_OPEN ? at : '0));
        view = state_q == ST_MOVING ? req : pend_q;
        hit = |(view & at);
        up_req = |(view & above);
        dn_req = |(view & below);
        ahead = dir_q == DIR_UP ? up_req : dn_req;
        behind = dir_q == DIR_UP ? dn_req : up_req;
        state_d = state_q;
        floor_d = floor_q;
        dir_d = dir_q;
        pend_d = req;
        t_load = 1'b0;
        t_val = TRAVEL_LOAD;
        if (state_q == ST_IDLE) begin
            if (hit) begin
                state_d = ST_DOOR_OPEN;
                pend_d = req & ~at;
                t_load = 1'b1;
                t_val = DOOR_LOAD;
            end else if (ahead || behind) begin
                state_d = ST_MOVING;
                dir_d = ahead ? dir_q : (dir_q == DIR_UP ? DIR_DOWN : DIR_UP);
                t_load = 1'b1;
            end
        end else if (state_q == ST_MOVING) begin
            if (t_zero) begin
                floor_d = step_floor;
                if (hit) begin
                    state_d = ST_DOOR_OPEN;
                    pend_d = req & ~at;
                    t_load = 1'b1;
                    t_val = DOOR_LOAD;
                end else if (ahead) t_load = 1'b1;
                else state_d = ST_IDLE;
            end
        end else begin
            // A call at the open floor keeps the door open instead of queueing a revisit
            if (door_call) begin
                t_load = 1'b1;
                t_val = DOOR_LOAD;
            end else if (t_zero) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            floor_q <= '0;
            dir_q <= DIR_UP;
            open_q <= 1'b0;
            moving_q <= 1'b0;
            pend_q <= '0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q <= dir_d;
            open_q <= state_d == ST_DOOR_OPEN;
            moving_q <= state_d == ST_MOVING;
            pend_q <= pend_d;
        end
    end

    assign current_floor = floor_q;
    assign direction = dir_q;
    assign open = open_q;
    assign moving = moving_q;
    assign pending = pend_q;
endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: directed and random calls scored against an array-based behavioural elevator model.
module tb_elevator_controller;
    localparam int NF = 8;
    localparam int TRAVEL = 4;
    localparam int DOOR = 3;
    localparam int PH_IDLE = 0;
    localparam int PH_MOV = 1;
    localparam int PH_DOOR = 2;

    typedef struct packed {
        logic [2:0] f;
        logic       d;
        logic       o;
        logic       m;
        logic [7:0] p;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] call_req = '0;
    logic [2:0] current_floor;
    logic       direction, open, moving;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;
    snap_t exp_q[$];

    int         m_floor = 0;
    int         m_phase = PH_IDLE;
    int         m_left = 0;
    bit         m_up = 1'b1;
    logic [7:0] m_pend = '0;

    elevator_controller #(
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .call_req      (call_req),
        .current_floor (current_floor),
        .direction     (direction),
        .open          (open),
        .moving        (moving),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    function automatic bit wanted(input logic [7:0] v, input int f, input bit up);
        for (int i = 0; i < NF; i++)
            if (v[i] && (up ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic r, input logic [7:0] c);
        logic [7:0] req;
        if (!r) begin
            m_floor = 0;
            m_up = 1'b1;
            m_phase = PH_IDLE;
            m_left = 0;
            m_pend = '0;
            return;
        end
        for (int i = 0; i < NF; i++)
            req[i] = m_pend[i] | (c[i] && !(m_phase == PH_DOOR && i == m_floor));
        case (m_phase)
            PH_IDLE: begin
                if (m_pend[m_floor]) begin
                    m_phase = PH_DOOR;
                    req[m_floor] = 1'b0;
                    m_left = DOOR - 1;
                end else if (wanted(m_pend, m_floor, m_up)) begin
                    m_phase = PH_MOV;
                    m_left = TRAVEL - 1;
                end else if (wanted(m_pend, m_floor, !m_up)) begin
                    m_up = !m_up;
                    m_phase = PH_MOV;
                    m_left = TRAVEL - 1;
                end
            end
            PH_MOV: begin
                if (m_left > 0) m_left--;
                else begin
                    m_floor += m_up ? 1 : -1;
                    if (req[m_floor]) begin
                        m_phase = PH_DOOR;
                        req[m_floor] = 1'b0;
                        m_left = DOOR - 1;
                    end else if (wanted(req, m_floor, m_up)) m_left = TRAVEL - 1;
                    else m_phase = PH_IDLE;
                end
            end
            default: begin
                if (c[m_floor]) m_left = DOOR - 1;
                else if (m_left > 0) m_left--;
                else m_phase = PH_IDLE;
            end
        endcase
        m_pend = req;
    endtask

    task automatic cyc(input logic r, input logic [7:0] c);
        snap_t s;
        @(negedge clk);
        rst_n = r;
        call_req = c;
        model_step(r, c);
        s.f = 3'(m_floor);
        s.d = m_up;
        s.o = m_phase == PH_DOOR;
        s.m = m_phase == PH_MOV;
        s.p = m_pend;
        exp_q.push_back(s);
    endtask

    task automatic check_now(input string nm, input logic [2:0] f, input logic o, input logic m,
                             input logic [7:0] p);
        @(posedge clk);
        #3;
        checks++;
        if ({current_floor, open, moving, pending} !== {f, o, m, p}) begin
            errors++;
            $display("FAIL %s got floor=%0d open=%b moving=%b pending=%h exp floor=%0d open=%b moving=%b pending=%h",
                     nm, current_floor, open, moving, pending, f, o, m, p);
        end
    endtask

    initial begin
        snap_t e, got;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got = {current_floor, direction, open, moving, pending};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL snapshot t=%0t got f=%0d d=%b o=%b m=%b p=%h exp f=%0d d=%b o=%b m=%b p=%h",
                             $time, got.f, got.d, got.o, got.m, got.p, e.f, e.d, e.o, e.m, e.p);
                end
            end
        end
    end

    initial begin
        bit reached;
        cyc(0, 8'hFF);
        cyc(0, 8'hFF);
        check_now("reset", 3'd0, 1'b0, 1'b0, 8'h00);
        cyc(1, 8'h00);
        check_now("post_reset", 3'd0, 1'b0, 1'b0, 8'h00);
        cyc(1, 8'h01);
        cyc(1, 8'h00);
        check_now("same_floor_open", 3'd0, 1'b1, 1'b0, 8'h00);
        cyc(1, 8'h00);
        cyc(1, 8'h00);
        cyc(1, 8'h00);
        check_now("same_floor_close", 3'd0, 1'b0, 1'b0, 8'h00);
        cyc(1, 8'h08);
        cyc(1, 8'h00);
        check_now("up_start", 3'd0, 1'b0, 1'b1, 8'h08);
        repeat (3) cyc(1, 8'h00);
        cyc(1, 8'h00);
        check_now("up_floor1", 3'd1, 1'b0, 1'b1, 8'h08);
        repeat (7) cyc(1, 8'h00);
        cyc(1, 8'h00);
        check_now("up_arrive3", 3'd3, 1'b1, 1'b0, 8'h00);
        repeat (4) cyc(1, 8'h00);
        cyc(1, 8'h22);
        repeat (60) cyc(1, 8'h00);
        cyc(1, 8'h04);
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            cyc(1, 8'h00);
            reached = m_phase == PH_DOOR && m_floor == 2;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL door_sync got no door at floor 2 exp door at floor 2");
        end
        repeat (4) begin
            cyc(1, 8'h04);
            cyc(1, 8'h00);
        end
        repeat (5) cyc(1, 8'h00);
        cyc(1, 8'h08);
        repeat (3) cyc(1, 8'h00);
        cyc(0, 8'h00);
        check_now("reset_mid_travel", 3'd0, 1'b0, 1'b0, 8'h00);
        cyc(1, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] c;
            c = $urandom_range(0, 5) == 0 ? 8'($urandom) :
                ($urandom_range(0, 7) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
            cyc($urandom_range(0, 299) != 0, c);
        end
        repeat (40) cyc(1, 8'h00);
        @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d left exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
